// File: rtl/gemv_quant_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Package   : gemv_pkg
// Purpose   : Shared widths, fixed-point constants and scale FSM encoding
//             for the GEMV arithmetic datapath.
// Revision  : 1.0 - initial release
// ============================================================================
package gemv_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int ACC_WIDTH  = 32;
  localparam int MUL_WIDTH  = 2 * ACC_WIDTH;
  localparam int FRAC_BITS  = 16;
  localparam int QMAX       = 127;
  localparam int CNT_W      = $clog2(ACC_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } scale_state_e;

endpackage
`default_nettype wire

// File: rtl/gemv_quant_datapath_if.sv
`default_nettype none
// ============================================================================
// Interface : gemv_quant_datapath_if
// Purpose   : Port bundle between the GEMV controller (master) and the
//             arithmetic datapath (slave): PE lane, scale calculator and
//             requantizer groups.
// Revision  : 1.0 - initial release
// ============================================================================
interface gemv_quant_datapath_if
  import gemv_pkg::*;
();

  // PE lane
  logic signed [DATA_WIDTH-1:0] pe_w;
  logic signed [DATA_WIDTH-1:0] pe_x;
  logic signed [PROD_WIDTH-1:0] pe_y;

  // Reciprocal-scale calculator
  logic                         scale_start;
  logic signed [ACC_WIDTH-1:0]  max_abs;
  logic signed [ACC_WIDTH-1:0]  reciprocal_scale;
  logic                         scale_ready;

  // Requantizer
  logic                         quant_valid_in;
  logic signed [ACC_WIDTH-1:0]  quant_int32;
  logic signed [DATA_WIDTH-1:0] quant_int8;
  logic                         quant_valid_out;

  modport master (
    output pe_w, pe_x, scale_start, max_abs, quant_valid_in, quant_int32,
    input  pe_y, reciprocal_scale, scale_ready, quant_int8, quant_valid_out
  );

  modport slave (
    input  pe_w, pe_x, scale_start, max_abs, quant_valid_in, quant_int32,
    output pe_y, reciprocal_scale, scale_ready, quant_int8, quant_valid_out
  );

endinterface
`default_nettype wire

// File: rtl/gemv_quant_datapath_quantizer_stage3.sv
`default_nettype none
// ============================================================================
// Module    : quantizer_stage3
// Purpose   : Back end of the requantizer: rounds the Q.FRAC_BITS product
//             half away from zero, then saturates to [-QMAX, QMAX].
//             Two register stages (pipeline stages 2 and 3).
// Revision  : 1.0 - initial release
// ============================================================================
module quantizer_stage3
  import gemv_pkg::*;
(
  input  wire                         clk,
  input  wire                         rst,
  input  wire                         i_valid,
  input  wire signed [MUL_WIDTH-1:0]  i_prod,
  output logic                        o_valid,
  output logic signed [DATA_WIDTH-1:0] o_q
);

  localparam logic [MUL_WIDTH-1:0] c_half = MUL_WIDTH'(1) << (FRAC_BITS - 1);

  logic                  w_neg;
  logic [MUL_WIDTH-1:0]  w_mag;
  logic [MUL_WIDTH-1:0]  r_mag;
  logic                  r_neg;
  logic                  r_v2;
  logic [DATA_WIDTH-1:0] w_sat_mag;
  logic signed [DATA_WIDTH-1:0] r_q;
  logic                  r_v3;

  // Sign/magnitude split; |p| never reaches 2^63 since both factors are 32b
  assign w_neg = i_prod[MUL_WIDTH-1];
  assign w_mag = w_neg ? MUL_WIDTH'(-i_prod) : MUL_WIDTH'(i_prod);

  // Clamp the rounded magnitude; symmetric range so -128 is never produced
  assign w_sat_mag = (r_mag > MUL_WIDTH'(QMAX)) ? DATA_WIDTH'(QMAX)
                                                : r_mag[DATA_WIDTH-1:0];

  // Stage 2: round magnitude half away from zero, carry sign alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag <= '0;
      r_neg <= 1'b0;
      r_v2  <= 1'b0;
    end else begin
      r_mag <= (w_mag + c_half) >> FRAC_BITS;
      r_neg <= w_neg;
      r_v2  <= i_valid;
    end
  end

  // Stage 3: saturate and reapply sign
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q  <= '0;
      r_v3 <= 1'b0;
    end else begin
      r_q  <= r_neg ? DATA_WIDTH'(-w_sat_mag) : w_sat_mag;
      r_v3 <= r_v2;
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_v3;

endmodule
`default_nettype wire

// File: rtl/gemv_quant_datapath.sv
`default_nettype none
// ============================================================================
// Module    : gemv_quant_datapath
// Purpose   : GEMV arithmetic core: registered int8 PE multiplier,
//             sequential reciprocal-scale divider (QMAX<<FRAC_BITS / max_abs)
//             and a 3-stage int32->int8 requantizer.
// Revision  : 1.0 - initial release
// ============================================================================
module gemv_quant_datapath
  import gemv_pkg::*;
(
  input  wire                  clk,
  input  wire                  rst,
  gemv_quant_datapath_if.slave dp
);

  localparam logic [ACC_WIDTH-1:0] c_dividend = ACC_WIDTH'(QMAX) << FRAC_BITS;

  // ---------------------------------------------------------------- PE lane
  logic signed [PROD_WIDTH-1:0] r_pe_y;

  // Full-precision signed product, one cycle latency, no enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pe_y <= '0;
    else     r_pe_y <= PROD_WIDTH'(dp.pe_w) * PROD_WIDTH'(dp.pe_x);
  end

  assign dp.pe_y = r_pe_y;

  // ------------------------------------------------------ scale calculator
  scale_state_e                r_state;
  scale_state_e                w_state_nxt;
  logic [ACC_WIDTH-1:0]        r_divisor;
  logic [ACC_WIDTH-1:0]        r_dvd;      // dividend shifts out, quotient shifts in
  logic [ACC_WIDTH-1:0]        r_rem;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_ready;
  logic signed [ACC_WIDTH-1:0] r_recip;
  logic [ACC_WIDTH:0]          w_trial;
  logic                        w_ge;
  logic [ACC_WIDTH-1:0]        w_rem_nxt;
  logic                        w_last;

  // Remainder stays below the divisor (< 2^31), so 32 bits plus one trial bit suffice
  assign w_trial   = {r_rem, r_dvd[ACC_WIDTH-1]};
  assign w_ge      = (w_trial >= {1'b0, r_divisor});
  assign w_rem_nxt = w_ge ? ACC_WIDTH'(w_trial - {1'b0, r_divisor})
                          : w_trial[ACC_WIDTH-1:0];
  assign w_last    = (r_cnt == CNT_W'(ACC_WIDTH - 1));

  // Scale FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Scale FSM next state; a dropped request always returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (dp.scale_start) w_state_nxt = S_DIV;
      S_DIV: begin
        if (!dp.scale_start) w_state_nxt = S_IDLE;
        else if (w_last)     w_state_nxt = S_DONE;
      end
      S_DONE: if (!dp.scale_start) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Restoring divider: one quotient bit per DIV clock, result latched on the last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divisor <= '0;
      r_dvd     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_recip   <= '0;
    end else begin
      r_ready <= (w_state_nxt == S_DONE);
      if (r_state == S_IDLE && dp.scale_start) begin
        // Non-positive max_abs would divide by zero; treat it as 1
        r_divisor <= (dp.max_abs <= 0) ? ACC_WIDTH'(1) : dp.max_abs;
        r_dvd     <= c_dividend;
        r_rem     <= '0;
        r_cnt     <= '0;
      end else if (r_state == S_DIV) begin
        r_dvd <= {r_dvd[ACC_WIDTH-2:0], w_ge};
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        if (dp.scale_start && w_last) r_recip <= {r_dvd[ACC_WIDTH-2:0], w_ge};
      end
    end
  end

  assign dp.reciprocal_scale = r_recip;
  assign dp.scale_ready      = r_ready;

  // ------------------------------------------------------------ quantizer
  logic signed [MUL_WIDTH-1:0]  r_prod;
  logic                         r_v1;
  logic                         w_qvalid;
  logic signed [DATA_WIDTH-1:0] w_q;

  // Stage 1: scale the accumulator by the current reciprocal (64b signed)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_prod <= MUL_WIDTH'(dp.quant_int32) * MUL_WIDTH'(r_recip);
      r_v1   <= dp.quant_valid_in;
    end
  end

  quantizer_stage3 u_stage3 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_v1),
    .i_prod  (r_prod),
    .o_valid (w_qvalid),
    .o_q     (w_q)
  );

  assign dp.quant_int8      = w_q;
  assign dp.quant_valid_out = w_qvalid;

endmodule
`default_nettype wire

// File: tb/tb_gemv_quant_datapath.sv
`default_nettype none
// ============================================================================
// Module    : tb_gemv_quant_datapath
// Purpose   : Self-checking bench for gemv_quant_datapath: directed PE,
//             reciprocal-scale and requantizer vectors against a plain
//             arithmetic model plus hand-computed literals.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_gemv_quant_datapath;
  import gemv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  gemv_quant_datapath_if u_if ();

  gemv_quant_datapath u_dut (
    .clk (clk),
    .rst (rst),
    .dp  (u_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference requantization: round-half-away-from-zero then symmetric clamp
  function automatic longint qmodel(input int x, input int recip);
    longint p, m, r;
    p = longint'(x) * longint'(recip);
    m = (p < 0) ? -p : p;
    r = (m + (longint'(1) << (FRAC_BITS - 1))) / (longint'(1) << FRAC_BITS);
    if (r > QMAX) r = QMAX;
    return (p < 0) ? -r : r;
  endfunction

  // Reference reciprocal scale
  function automatic longint smodel(input int ma);
    longint d;
    d = (ma <= 0) ? 1 : ma;
    return (longint'(QMAX) * (longint'(1) << FRAC_BITS)) / d;
  endfunction

  // Model state: expected PE product and a 3-deep quantizer delay line
  longint m_pe;
  bit     m_v [3];
  longint m_q [3];
  int     m_recip;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pe <= 0;
      m_v  <= '{default: 1'b0};
      m_q  <= '{default: 0};
    end else begin
      m_pe   <= longint'(u_if.pe_w) * longint'(u_if.pe_x);
      m_v[0] <= u_if.quant_valid_in;
      m_q[0] <= qmodel(u_if.quant_int32, m_recip);
      m_v[1] <= m_v[0];
      m_q[1] <= m_q[0];
      m_v[2] <= m_v[1];
      m_q[2] <= m_q[1];
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("pe_y", u_if.pe_y, m_pe);
      chk("quant_valid_out", u_if.quant_valid_out, m_v[2]);
      if (m_v[2]) chk("quant_int8", u_if.quant_int8, m_q[2]);
    end
  end

  task automatic run_scale(input int ma, input int lit);
    int  k;
    bit  got;
    @(negedge clk);
    u_if.max_abs     = ma;
    u_if.scale_start = 1'b1;
    k   = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (u_if.scale_ready) got = 1'b1;
    end
    chk("scale_latency", k, 33);
    chk("recip_model", u_if.reciprocal_scale, smodel(ma));
    chk("recip_literal", u_if.reciprocal_scale, lit);
    @(negedge clk);
    chk("ready_hold", u_if.scale_ready, 1);
    u_if.scale_start = 1'b0;
    u_if.max_abs     = 0;
    @(negedge clk);
    chk("ready_drop", u_if.scale_ready, 0);
    chk("recip_keep", u_if.reciprocal_scale, lit);
    m_recip = lit;
  endtask

  task automatic run_quant(input int n, input int vals[4], input int lits[4]);
    for (int t = 0; t <= n + 3; t++) begin
      @(negedge clk);
      if (t == 2) chk("quant_not_early", u_if.quant_valid_out, 0);
      if (t >= 3 && t - 3 < n) begin
        chk("quant_valid_lit", u_if.quant_valid_out, 1);
        chk("quant_int8_lit", u_if.quant_int8, lits[t-3]);
      end
      if (t == n + 3) chk("quant_valid_tail", u_if.quant_valid_out, 0);
      if (t < n) begin
        u_if.quant_valid_in = 1'b1;
        u_if.quant_int32    = vals[t];
      end else begin
        u_if.quant_valid_in = 1'b0;
        u_if.quant_int32    = int'($urandom);
      end
    end
  endtask

  initial begin
    int seen;
    u_if.pe_w           = '0;
    u_if.pe_x           = '0;
    u_if.scale_start    = 1'b0;
    u_if.max_abs        = '0;
    u_if.quant_valid_in = 1'b0;
    u_if.quant_int32    = '0;
    m_recip             = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pe_y", u_if.pe_y, 0);
    chk("rst_ready", u_if.scale_ready, 0);
    chk("rst_recip", u_if.reciprocal_scale, 0);
    chk("rst_valid_out", u_if.quant_valid_out, 0);
    chk("rst_int8", u_if.quant_int8, 0);
    #2 rst = 1'b0;

    // PE extremes
    @(negedge clk);
    u_if.pe_w = -8'sd128;
    u_if.pe_x = -8'sd128;
    @(negedge clk);
    chk("pe_neg_neg", u_if.pe_y, 16384);
    u_if.pe_w = 8'sd127;
    u_if.pe_x = -8'sd128;
    @(negedge clk);
    chk("pe_pos_neg", u_if.pe_y, -16256);
    u_if.pe_w = 8'sd0;
    u_if.pe_x = 8'sd0;

    // Reciprocal scale, including non-positive max_abs
    run_scale(127, 65536);
    run_scale(0, 8323072);
    run_scale(-5, 8323072);

    // Dropping start mid-division aborts without touching the result
    @(negedge clk);
    u_if.max_abs     = 1000;
    u_if.scale_start = 1'b1;
    repeat (10) @(negedge clk);
    u_if.scale_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.scale_ready) seen = 1;
    end
    chk("abort_ready", seen, 0);
    chk("abort_recip_keep", u_if.reciprocal_scale, 8323072);

    run_scale(1000, 8323);
    run_quant(3, '{1000, -500, 0, 0}, '{127, -63, 0, 0});

    run_scale(127, 65536);
    run_quant(2, '{500, -200, 0, 0}, '{127, -127, 0, 0});
    run_quant(4, '{65, -66, 32767, -32768}, '{65, -66, 127, -127});

    // Asynchronous reset during DIV with a full quantizer pipeline
    @(negedge clk);
    u_if.max_abs     = 1000;
    u_if.scale_start = 1'b1;
    u_if.pe_w        = 8'sd5;
    u_if.pe_x        = 8'sd7;
    repeat (8) @(negedge clk);
    u_if.quant_valid_in = 1'b1;
    u_if.quant_int32    = 1000;
    @(negedge clk);
    u_if.quant_int32    = -500;
    @(negedge clk);
    u_if.quant_int32    = 77;
    @(negedge clk);
    chk("pre_rst_valid", u_if.quant_valid_out, 1);
    #2 rst = 1'b1;
    m_recip = 0;
    #1;
    chk("arst_ready", u_if.scale_ready, 0);
    chk("arst_valid_out", u_if.quant_valid_out, 0);
    chk("arst_pe_y", u_if.pe_y, 0);
    chk("arst_int8", u_if.quant_int8, 0);
    chk("arst_recip", u_if.reciprocal_scale, 0);
    u_if.scale_start    = 1'b0;
    u_if.quant_valid_in = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", u_if.scale_ready, 0);
    chk("post_rst_pe_y", u_if.pe_y, 35);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
